systolic_sequencer: RTL and testbench
=====================================

# systolic_sequencer

Controller that owns the `systolic_processorVCounter` array: it buffers one A and one B matrix written by a host and resets the array's accumulators. It then streams skewed row and column vectors into `i_a_full`/`i_b_full`, waits for the wavefront to drain, and captures `o_c_full` into a result register with a one-cycle valid pulse. It sits between the host/bus side and the array. The array itself is unchanged.

## Interface
- `SIZE`, 8: matrix dimension N; must match the array.
- `I_BITS`, 8: operand width, unsigned.
- `O_BITS`, `2*I_BITS+$clog2(SIZE)`: result element width.
- `i_clock`  in  1  single clock, rising edge.
- `i_reset`  in  1  asynchronous, active-low; clears all state.
- `i_wr_valid`  in  1  host write strobe for one matrix row.
- `i_wr_sel`  in  1  0 = matrix A, 1 = matrix B.
- `i_wr_row`  in  $clog2(SIZE)  row index.
- `i_wr_data`  in  SIZE*I_BITS  row data; element j at bits [I_BITS*j +: I_BITS].
- `i_start`  in  1  start request, one-cycle pulse or level.
- `o_ready`  out  1  high in IDLE/DONE; writes and start are accepted only then.
- `o_busy`  out  1  high in CLEAR/FEED/DRAIN.
- `o_array_reset`  out  1  to array `i_reset`; active-high, synchronous to array.
- `o_a_full`  out  SIZE*I_BITS  to array `i_a_full`.
- `o_b_full`  out  SIZE*I_BITS  to array `i_b_full`.
- `i_c_full`  in  SIZE*SIZE*O_BITS  from array `o_c_full`.
- `o_c_full`  out  SIZE*SIZE*O_BITS  captured result; element k=i*SIZE+j.
- `o_c_valid`  out  1  one-cycle pulse when `o_c_full` updates.

## Operation
- FSM states and transitions:
  - IDLE: on `i_start`, go to CLEAR.
  - CLEAR: lasts 1 cycle, then FEED.
  - FEED: lasts 2N-1 cycles, then DRAIN.
  - DRAIN: lasts N cycles, then DONE.
  - DONE: lasts 1 cycle, then IDLE.
  - `i_start` in DONE also goes to CLEAR, enabling back-to-back runs.
- Writes: when `i_wr_valid & o_ready`, store row `i_wr_row` of the selected matrix. Writes outside IDLE/DONE are dropped with no error. The buffers persist across runs; rewrite only what changes.
- Write and `i_start` in the same cycle: the write commits on that edge and is used by the run.
- `i_start` while busy is ignored.
- CLEAR: `o_array_reset`=1, and `o_a_full`/`o_b_full` are driven to 0.
- FEED, step counter t=0..2N-2, lane q:
  - `o_a_full` lane q = A[q][t-q] if 0≤t-q<N, else 0.
  - `o_b_full` lane q = B[t-q][q] under the same condition.
- DRAIN: all lanes 0 while the array finishes its accumulations.
- DONE: `o_c_full` ← `i_c_full`, `o_c_valid`=1 for exactly this cycle.
- Arithmetic is unsigned. No saturation is needed because O_BITS covers N·(2^I_BITS−1)².

## Timing
- Reset values: state IDLE, counter 0, `o_ready`=1, `o_busy`=0, `o_array_reset`=1, `o_a_full`=`o_b_full`=0, `o_c_full`=0, `o_c_valid`=0. Buffers clear to 0.
- In IDLE, `o_array_reset` stays 0 after the first clock edge following reset release.
- All outputs are registered. Lane data is valid on the same edge the array samples it.
- Latency from the `i_start` edge to the `o_c_valid` edge: 1 + (2N-1) + N + 1 = 3N+1 cycles (25 for N=8). Back-to-back period is 3N+1 cycles.
- Asynchronous reset mid-run returns to IDLE immediately and drops the run; `o_c_full` clears.
- Step counter width is $clog2(2*SIZE). It never wraps within a state; it reloads to 0 on each state entry.

## Structure
- Shared package holds:
  - FSM state encoding: IDLE, CLEAR, FEED, DRAIN, DONE.
  - Default-width function for O_BITS.
  - Lane slice helper macros, shared with the array and the bench.
- One sub-module, `skew_feeder`: given buffer row/column, t, and a lane index, it produces a gated lane value. It is instantiated per lane for A and for B.
- FSM, counter, buffers, and result capture stay in the top level.

## Test plan
- N=4, A=I, B=[[1..4],[5..8],[9..12],[13..16]], start → `o_c_valid` at cycle 13 after start; C=B.
- All elements 255 in A and B (N=4) → every C element = 260100 with no overflow at O_BITS=18.
- Start asserted in the same cycle as the final B row write → the result reflects the new row.
- Writes and `i_start` issued during FEED → ignored; the result equals that of the original matrices; no second run occurs.
- Async reset asserted at FEED t=3 → outputs at reset values; after release, a fresh start gives the correct C.
- Two runs with `i_start` held high → `o_c_valid` pulses 13 cycles apart; `o_array_reset` pulses before each run, so the second C is not accumulated onto the first.

Source files
------------

// File: rtl/systolic_sequencer_pkg.sv
// Purpose: shared FSM encoding, result-width helper and lane slice macros for the sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: seq_state_t, o_bits_default(), SS_LANE / SS_C_ELEM macros.

`ifndef SYSTOLIC_SEQUENCER_LANE_MACROS
`define SYSTOLIC_SEQUENCER_LANE_MACROS
// Element idx of a flat vector of w-bit lanes.
`define SS_LANE(vec, idx, w) vec[(idx)*(w) +: (w)]
// Element (i,j) of a flat row-major n x n matrix of w-bit entries.
`define SS_C_ELEM(vec, i, j, n, w) vec[((i)*(n)+(j))*(w) +: (w)]
`endif

package systolic_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FEED  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } seq_state_t;

  // Wide enough for size * (2^i_bits - 1)^2 without overflow.
  function automatic int o_bits_default(input int size, input int i_bits);
    return 2 * i_bits + $clog2(size);
  endfunction

endpackage

// File: rtl/systolic_sequencer_skew.sv
// Purpose: one skewed feed lane; picks element (t - lane) of a buffered row/column, else 0.
// Latency: combinational, 0 cycles.
// Backpressure: none; output follows inputs every cycle.
// Ports: en (feed active), t (step), lane (lane index), vec (row/column source), value (gated lane).

module skew_feeder
  import systolic_sequencer_pkg::*;
#(
  parameter int SIZE   = 8,
  parameter int I_BITS = 8,
  parameter int CW     = 4,
  parameter int LW     = 3
) (
  input  logic                   en,
  input  logic [CW-1:0]          t,
  input  logic [LW-1:0]          lane,
  input  logic [SIZE*I_BITS-1:0] vec,
  output logic [I_BITS-1:0]      value
);

  // One spare bit so t - lane can be compared without sign tricks.
  logic [CW:0] t_ext;
  logic [CW:0] lane_ext;
  logic [CW:0] d;
  logic        in_window;

  assign t_ext     = {1'b0, t};
  assign lane_ext  = (CW+1)'(lane);
  assign d         = t_ext - lane_ext;
  assign in_window = en && (t_ext >= lane_ext) && (d < (CW+1)'(SIZE));

  always_comb begin
    value = '0;
    for (int k = 0; k < SIZE; k++) begin
      if (in_window && (d == (CW+1)'(k))) begin
        value = `SS_LANE(vec, k, I_BITS);
      end
    end
  end

endmodule

// File: rtl/systolic_sequencer.sv
// Purpose: buffers host A/B matrices, clears the systolic array, feeds skewed lanes, captures C.
// Latency: start cycle to o_c_valid cycle = 3*SIZE+1 cycles (CLEAR 1, FEED 2N-1, DRAIN N, DONE 1).
// Backpressure: writes/start accepted only while o_ready; anything offered while busy is dropped.
// Ports: host side i_wr_* / i_start / o_ready / o_busy; array side o_array_reset, o_a_full,
//        o_b_full, i_c_full; result side o_c_full / o_c_valid.

module systolic_sequencer
  import systolic_sequencer_pkg::*;
#(
  parameter int SIZE   = 8,
  parameter int I_BITS = 8,
  parameter int O_BITS = o_bits_default(SIZE, I_BITS)
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic                          i_wr_valid,
  input  logic                          i_wr_sel,
  input  logic [$clog2(SIZE)-1:0]       i_wr_row,
  input  logic [SIZE*I_BITS-1:0]        i_wr_data,
  input  logic                          i_start,
  output logic                          o_ready,
  output logic                          o_busy,
  output logic                          o_array_reset,
  output logic [SIZE*I_BITS-1:0]        o_a_full,
  output logic [SIZE*I_BITS-1:0]        o_b_full,
  input  logic [SIZE*SIZE*O_BITS-1:0]   i_c_full,
  output logic [SIZE*SIZE*O_BITS-1:0]   o_c_full,
  output logic                          o_c_valid
);

  localparam int RW = $clog2(SIZE);
  localparam int CW = $clog2(2 * SIZE);
  localparam logic [CW-1:0] FEED_LAST  = CW'(2 * SIZE - 2);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(SIZE - 1);

  seq_state_t state, nxt_state;
  logic [CW-1:0] cnt, nxt_cnt;

  logic nxt_ready;
  logic nxt_busy;
  logic nxt_array_reset;
  logic nxt_feed;
  logic nxt_done;

  logic [SIZE*I_BITS-1:0] a_buf [SIZE];
  logic [SIZE*I_BITS-1:0] b_buf [SIZE];
  logic [SIZE*I_BITS-1:0] b_col [SIZE];
  logic [SIZE*I_BITS-1:0] a_lanes;
  logic [SIZE*I_BITS-1:0] b_lanes;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= nxt_state;
      cnt   <= nxt_cnt;
    end
  end

  always_comb begin
    nxt_state = state;
    case (state)
      ST_IDLE:  if (i_start) nxt_state = ST_CLEAR;
      ST_CLEAR: nxt_state = ST_FEED;
      ST_FEED:  if (cnt == FEED_LAST) nxt_state = ST_DRAIN;
      ST_DRAIN: if (cnt == DRAIN_LAST) nxt_state = ST_DONE;
      ST_DONE:  nxt_state = i_start ? ST_CLEAR : ST_IDLE;
      default:  nxt_state = ST_IDLE;
    endcase

    // Counter restarts at every state entry and idles at 0, so it never wraps.
    if ((nxt_state != state) || (state == ST_IDLE)) begin
      nxt_cnt = '0;
    end else begin
      nxt_cnt = cnt + CW'(1);
    end

    // Outputs are registered from the next state so they line up with it.
    nxt_ready       = (nxt_state == ST_IDLE) || (nxt_state == ST_DONE);
    nxt_busy        = (nxt_state == ST_CLEAR) || (nxt_state == ST_FEED) ||
                      (nxt_state == ST_DRAIN);
    nxt_array_reset = (nxt_state == ST_CLEAR);
    nxt_feed        = (nxt_state == ST_FEED);
    nxt_done        = (nxt_state == ST_DONE);
  end

  // ---------------------------------------------------------------- buffers
  // o_ready is the registered IDLE/DONE flag, so it gates writes directly.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      for (int r = 0; r < SIZE; r++) begin
        a_buf[r] <= '0;
        b_buf[r] <= '0;
      end
    end else if (i_wr_valid && o_ready) begin
      for (int r = 0; r < SIZE; r++) begin
        if (i_wr_row == RW'(r)) begin
          if (i_wr_sel) begin
            b_buf[r] <= i_wr_data;
          end else begin
            a_buf[r] <= i_wr_data;
          end
        end
      end
    end
  end

  // B lane q walks down column q, so transpose the row-organised buffer.
  always_comb begin
    for (int q = 0; q < SIZE; q++) begin
      b_col[q] = '0;
      for (int r = 0; r < SIZE; r++) begin
        `SS_LANE(b_col[q], r, I_BITS) = `SS_LANE(b_buf[r], q, I_BITS);
      end
    end
  end

  // ---------------------------------------------------------------- lanes
  for (genvar q = 0; q < SIZE; q++) begin : g_lane
    skew_feeder #(
      .SIZE   (SIZE),
      .I_BITS (I_BITS),
      .CW     (CW),
      .LW     (RW)
    ) u_feed_a (
      .en    (nxt_feed),
      .t     (nxt_cnt),
      .lane  (RW'(q)),
      .vec   (a_buf[q]),
      .value (a_lanes[q*I_BITS +: I_BITS])
    );

    skew_feeder #(
      .SIZE   (SIZE),
      .I_BITS (I_BITS),
      .CW     (CW),
      .LW     (RW)
    ) u_feed_b (
      .en    (nxt_feed),
      .t     (nxt_cnt),
      .lane  (RW'(q)),
      .vec   (b_col[q]),
      .value (b_lanes[q*I_BITS +: I_BITS])
    );
  end

  // ---------------------------------------------------------------- outputs
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      o_ready       <= 1'b1;
      o_busy        <= 1'b0;
      o_array_reset <= 1'b1;
      o_a_full      <= '0;
      o_b_full      <= '0;
      o_c_full      <= '0;
      o_c_valid     <= 1'b0;
    end else begin
      o_ready       <= nxt_ready;
      o_busy        <= nxt_busy;
      o_array_reset <= nxt_array_reset;
      o_a_full      <= a_lanes;
      o_b_full      <= b_lanes;
      o_c_valid     <= nxt_done;
      // The last DRAIN cycle already shows the final accumulations.
      if (nxt_done) begin
        o_c_full <= i_c_full;
      end
    end
  end

endmodule

// File: tb/tb_systolic_sequencer.sv
// Purpose: directed self-checking bench for systolic_sequencer with a behavioural N=4 array.
// Latency: expects o_c_valid 13 cycles after the start cycle.
// Backpressure: exercises writes/start dropped while busy.

module tb_systolic_sequencer;

  localparam int N  = 4;
  localparam int IB = 8;
  localparam int OB = 18;
  localparam int CV = N * N * OB;

  localparam logic [31:0] B1 [4] = '{32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D};
  localparam logic [31:0] B3 [4] = '{32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h67666564};

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          wr_valid = 1'b0;
  logic          wr_sel = 1'b0;
  logic [1:0]    wr_row = '0;
  logic [31:0]   wr_data = '0;
  logic          start = 1'b0;
  logic          ready, busy, arr_rst, c_valid;
  logic [31:0]   a_full, b_full;
  logic [CV-1:0] c_in, c_out;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  systolic_sequencer #(.SIZE(N), .I_BITS(IB), .O_BITS(OB)) dut (
    .i_clock       (clk),
    .i_reset       (rst_n),
    .i_wr_valid    (wr_valid),
    .i_wr_sel      (wr_sel),
    .i_wr_row      (wr_row),
    .i_wr_data     (wr_data),
    .i_start       (start),
    .o_ready       (ready),
    .o_busy        (busy),
    .o_array_reset (arr_rst),
    .o_a_full      (a_full),
    .o_b_full      (b_full),
    .i_c_full      (c_in),
    .o_c_full      (c_out),
    .o_c_valid     (c_valid)
  );

  // Behavioural output-stationary array: A flows right, B flows down, sync clear.
  logic [IB-1:0] ar [N][N];
  logic [IB-1:0] br [N][N];
  logic [IB-1:0] a_in [N][N];
  logic [IB-1:0] b_in [N][N];
  logic [OB-1:0] acc [N][N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      a_in[i][0] = a_full[i*IB +: IB];
      b_in[0][i] = b_full[i*IB +: IB];
      for (int j = 1; j < N; j++) begin
        a_in[i][j] = ar[i][j-1];
        b_in[j][i] = br[j-1][i];
      end
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (arr_rst) begin
          ar[i][j]  <= '0;
          br[i][j]  <= '0;
          acc[i][j] <= '0;
        end else begin
          ar[i][j]  <= a_in[i][j];
          br[i][j]  <= b_in[i][j];
          acc[i][j] <= acc[i][j] + OB'(a_in[i][j]) * OB'(b_in[i][j]);
        end
      end
    end
  end

  always_comb begin
    c_in = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        c_in[(i*N+j)*OB +: OB] = acc[i][j];
      end
    end
  end

  // ---------------------------------------------------------------- helpers
  task automatic chk(input string tag, input logic [CV-1:0] got, input logic [CV-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic sel, input int row, input logic [31:0] d);
    wr_valid = 1'b1;
    wr_sel   = sel;
    wr_row   = row[1:0];
    wr_data  = d;
    tick();
    wr_valid = 1'b0;
  endtask

  // With A = I, C equals B: element (i,j) is byte j of row i.
  function automatic logic [CV-1:0] c_from_rows(input logic [31:0] rows [4]);
    logic [CV-1:0] e;
    logic [31:0]   r;
    e = '0;
    for (int i = 0; i < N; i++) begin
      r = rows[i];
      for (int j = 0; j < N; j++) begin
        e[(i*N+j)*OB +: OB] = OB'(r[j*IB +: IB]);
      end
    end
    return e;
  endfunction

  task automatic load_identity();
    for (int r = 0; r < N; r++) wr(1'b0, r, 32'h1 << (8 * r));
  endtask

  task automatic wait_valid(input int n0, output int n);
    n = n0;
    while (c_valid !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
  endtask

  task automatic run(output int n);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid(1, n);
  endtask

  // ---------------------------------------------------------------- watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "bench did not finish");
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    int n;
    int pulses;
    logic seen;
    logic [CV-1:0] all_full;

    all_full = '0;
    for (int k = 0; k < N * N; k++) all_full[k*OB +: OB] = 18'd260100;

    // Reset values
    #1 rst_n = 1'b0;
    #1;
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_arr_rst", arr_rst, 1);
    chk("rst_a", a_full, 0);
    chk("rst_b", b_full, 0);
    chk("rst_c", c_out, 0);
    chk("rst_valid", c_valid, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_arr_rst", arr_rst, 0);

    // Test 1: A = I, B = 1..16, with lane checks along the way
    load_identity();
    for (int r = 0; r < N; r++) wr(1'b1, r, B1[r]);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("clear_arr_rst", arr_rst, 1);
    chk("clear_busy", busy, 1);
    chk("clear_ready", ready, 0);
    chk("clear_a", a_full, 0);
    tick();
    chk("t0_a", a_full, 32'h00000001);
    chk("t0_b", b_full, 32'h00000001);
    tick();
    chk("t1_a", a_full, 32'h00000000);
    chk("t1_b", b_full, 32'h00000205);
    tick();
    chk("t2_a", a_full, 32'h00000100);
    tick();
    chk("t3_b", b_full, 32'h04070A0D);
    wait_valid(5, n);
    chk("t1_latency", n, 13);
    chk("t1_c", c_out, c_from_rows(B1));
    chk("done_ready", ready, 1);
    tick();
    chk("valid_pulse", c_valid, 0);
    chk("idle_again_arr_rst", arr_rst, 0);

    // Test 2: all-255 operands, maximum accumulation
    for (int r = 0; r < N; r++) wr(1'b0, r, 32'hFFFFFFFF);
    for (int r = 0; r < N; r++) wr(1'b1, r, 32'hFFFFFFFF);
    run(n);
    chk("max_latency", n, 13);
    chk("max_c", c_out, all_full);
    tick();

    // Test 3: last B row written in the same cycle as start
    load_identity();
    for (int r = 0; r < N - 1; r++) wr(1'b1, r, B3[r]);
    wr_valid = 1'b1;
    wr_sel   = 1'b1;
    wr_row   = 2'd3;
    wr_data  = B3[3];
    start    = 1'b1;
    tick();
    wr_valid = 1'b0;
    start    = 1'b0;
    wait_valid(1, n);
    chk("samecyc_latency", n, 13);
    chk("samecyc_c", c_out, c_from_rows(B3));
    tick();

    // Test 4: write and start during FEED are dropped
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    wr_valid = 1'b1;
    wr_sel   = 1'b0;
    wr_row   = 2'd0;
    wr_data  = 32'h07070707;
    start    = 1'b1;
    tick();
    wr_valid = 1'b0;
    start    = 1'b0;
    wait_valid(5, n);
    chk("busy_wr_latency", n, 13);
    chk("busy_wr_c", c_out, c_from_rows(B3));
    pulses = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (c_valid) pulses++;
    end
    chk("no_rerun", pulses, 0);
    chk("no_rerun_busy", busy, 0);

    // Test 5: async reset at FEED t=3
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ready", ready, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_arr_rst", arr_rst, 1);
    chk("midrst_a", a_full, 0);
    chk("midrst_b", b_full, 0);
    chk("midrst_c", c_out, 0);
    chk("midrst_valid", c_valid, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    run(n);
    chk("cleared_buf_c", c_out, 0);
    tick();
    load_identity();
    for (int r = 0; r < N; r++) wr(1'b1, r, B1[r]);
    run(n);
    chk("post_rst_latency", n, 13);
    chk("post_rst_c", c_out, c_from_rows(B1));
    tick();

    // Test 6: start held high gives back-to-back runs
    start = 1'b1;
    tick();
    wait_valid(1, n);
    chk("b2b_latency1", n, 13);
    chk("b2b_c1", c_out, c_from_rows(B1));
    tick();
    n = 1;
    seen = arr_rst;
    while (c_valid !== 1'b1 && n < 60) begin
      tick();
      n++;
      if (arr_rst) seen = 1'b1;
    end
    start = 1'b0;
    chk("b2b_period", n, 13);
    chk("b2b_clear_seen", seen, 1);
    chk("b2b_c2", c_out, c_from_rows(B1));
    tick();
    chk("b2b_end_valid", c_valid, 0);
    chk("b2b_end_busy", busy, 0);
    chk("b2b_end_ready", ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
